// File: rtl/mem_access_if.sv
// Load/store request, response and RAM-port bundle for mem_access_unit.
// Pure wiring, no latency of its own.
// Handshakes are valid/ready on the request and response channels.
interface mem_access_if #(
  parameter int D_BITS = 32,
  parameter int ADDR_W = 5
);
  // CPU request channel (byte address, right-aligned store data)
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [D_BITS-1:0] req_wdata;

  // CPU response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [D_BITS-1:0] rsp_rdata;
  logic              rsp_err;

  // Word-wide single-port RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [D_BITS-1:0] ram_din;
  logic              ram_we;
  logic [D_BITS-1:0] ram_dout;

  // The access unit: serves requests and drives the RAM port
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_addr, ram_din, ram_we
  );

  // The environment: CPU issuing requests and the RAM answering reads
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator in front of a word-wide RAM without byte enables.
// Latency accept->rsp_valid: error 1, load 2, word store 2, byte/half store 3 (RMW) cycles.
// One access in flight; req_ready low until the response handshake; response held while rsp_ready low.
module mem_access_unit #(
  parameter int D_BITS = 32,  // only 32 is supported
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  mem_access_if.slave  bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_q, state_d;

  // Request fields captured at accept
  logic              we_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              uns_q;
  logic [15:0]       wdata_q;   // only the low half is ever merged into a word

  // Registered outputs and their next values
  logic [ADDR_W-1:0] ram_addr_q;
  logic [D_BITS-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic [D_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              misalign;

  // Right-align the addressed lane and sign/zero-extend it
  function automatic logic [D_BITS-1:0] load_extend(
    input logic [D_BITS-1:0] word,
    input logic [1:0]        size,
    input logic [1:0]        off,
    input logic              uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the addressed byte/half lane of the RAM word with store data
  function automatic logic [D_BITS-1:0] store_merge(
    input logic [D_BITS-1:0] word,
    input logic [15:0]       data,
    input logic [1:0]        size,
    input logic [1:0]        off
  );
    logic [D_BITS-1:0] r;
    r = word;
    if (size == SZ_HALF) begin
      if (off[1]) r[31:16] = data;
      else        r[15:0]  = data;
    end else begin
      case (off)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end
    return r;
  endfunction

  assign accept   = bus.req_valid & (state_q == IDLE);
  assign misalign = (bus.req_size == 2'b11) ||
                    ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                    ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  // Next state plus next values of the registered RAM/response outputs
  always_comb begin
    state_d     = state_q;
    ram_we_d    = 1'b0;
    ram_din_d   = ram_din_q;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          err_d       = misalign;
          rsp_rdata_d = '0;
          if (misalign) begin
            state_d = RESP;
          end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
            // full-word store needs no read: write straight away
            state_d   = WRITE;
            ram_we_d  = 1'b1;
            ram_din_d = bus.req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d   = WRITE;
          ram_we_d  = 1'b1;
          ram_din_d = store_merge(bus.ram_dout, wdata_q, size_q, off_q);
        end else begin
          state_d     = RESP;
          rsp_rdata_d = load_extend(bus.ram_dout, size_q, off_q, uns_q);
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_rdata_d = '0;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, registered outputs and request capture; reset aborts any access at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      ram_addr_q  <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
      if (accept) begin
        we_q       <= bus.req_we;
        size_q     <= bus.req_size;
        off_q      <= bus.req_addr[1:0];
        uns_q      <= bus.req_unsigned;
        wdata_q    <= bus.req_wdata[15:0];
        ram_addr_q <= bus.req_addr[ADDR_W+1:2];
      end
    end
  end

  assign bus.req_ready = rst_n & (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = err_q & (state_q == RESP);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.ram_we    = ram_we_q;

endmodule
